// File: rtl/sdpb_arb_pkg.sv
`default_nettype none
// ============================================================================
// sdpb_arb_pkg : shared widths and enums for the dual-port block-RAM arbiter
// Revision     : 1.0
// ============================================================================
package sdpb_arb_pkg;

    localparam int SDPB_ADDR_W = 13;
    localparam int SDPB_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } rd_owner_t;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_DRAIN = 2'd2
    } arb_mode_t;

endpackage
`default_nettype wire

// File: rtl/sdpb_rd_sched.sv
`default_nettype none
// ============================================================================
// sdpb_rd_sched : read-port arbitration, CPU anti-starvation, response routing
//                 and same-cycle write-to-read forwarding
// Revision      : 1.0
// ============================================================================
module sdpb_rd_sched
    import sdpb_arb_pkg::*;
#(
    parameter int ADDR_W          = SDPB_ADDR_W,
    parameter int DATA_W          = SDPB_DATA_W,
    parameter int MAX_VIDEO_BURST = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              cpu_rreq,
    input  logic [ADDR_W-1:0] cpu_raddr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              vid_gnt,
    output logic              cpu_rgnt,
    output logic              vid_rvalid,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb
);

    localparam int          CNT_W     = 8;
    localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_VIDEO_BURST);

    logic [CNT_W-1:0]  starve_q, starve_d;
    rd_owner_t         owner_q, owner_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] fwd_q, fwd_d;
    logic              w_cpu_cand;
    logic              w_force_cpu;

    always_comb begin
        w_cpu_cand  = run && cpu_rreq;
        // Video wins every contested cycle until the CPU has waited a full burst.
        w_force_cpu = w_cpu_cand && vid_req && (starve_q == C_MAX_BURST);
        vid_gnt     = vid_req && !w_force_cpu;
        cpu_rgnt    = w_cpu_cand && (!vid_req || w_force_cpu);
        ram_ceb     = vid_gnt || cpu_rgnt;
        ram_adb     = vid_gnt ? vid_addr : cpu_raddr;

        starve_d = starve_q;
        if (!cpu_rreq || cpu_rgnt) begin
            starve_d = '0;
        end else if (vid_gnt && run) begin
            starve_d = starve_q + CNT_W'(1);
        end

        owner_d = OWN_NONE;
        if (vid_gnt) begin
            owner_d = OWN_VID;
        end else if (cpu_rgnt) begin
            owner_d = OWN_CPU;
        end

        hit_d = wr_en && ram_ceb && (wr_addr == ram_adb);
        fwd_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
            hit_q    <= 1'b0;
            fwd_q    <= '0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            hit_q    <= hit_d;
            fwd_q    <= fwd_d;
        end
    end

    assign vid_rvalid = (owner_q == OWN_VID);
    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign rd_data    = hit_q ? fwd_q : ram_dout;

endmodule
`default_nettype wire

// File: rtl/sdpb_arbiter.sv
`default_nettype none
// ============================================================================
// sdpb_arbiter : shares an 8K x 16 simple dual-port RAM between video, CPU and
//                boot loader; holds the mode FSM and the write-port mux
// Revision     : 1.0
// ============================================================================
module sdpb_arbiter
    import sdpb_arb_pkg::*;
#(
    parameter int ADDR_W          = SDPB_ADDR_W,
    parameter int DATA_W          = SDPB_DATA_W,
    parameter int MAX_VIDEO_BURST = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_rreq,
    input  logic [ADDR_W-1:0] cpu_raddr,
    output logic              cpu_rgnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_wreq,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_wgnt,
    input  logic              ld_active,
    input  logic              ld_wreq,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_wgnt,
    output logic              cpu_hold,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_oce,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_mode_t         mode_q, mode_d;
    logic [1:0]        drain_q, drain_d;
    logic              cpu_hold_q;
    logic [DATA_W-1:0] w_rd_data;

    always_comb begin
        mode_d  = mode_q;
        drain_d = drain_q;
        case (mode_q)
            MODE_RUN: begin
                if (ld_active) mode_d = MODE_LOAD;
            end
            MODE_LOAD: begin
                if (!ld_active) begin
                    mode_d  = MODE_DRAIN;
                    drain_d = 2'd2;
                end
            end
            MODE_DRAIN: begin
                drain_d = drain_q - 2'd1;
                if (ld_active) begin
                    mode_d = MODE_LOAD;
                end else if (drain_q <= 2'd1) begin
                    mode_d = MODE_RUN;
                end
            end
            default: mode_d = MODE_DRAIN;
        endcase
    end

    // Hold is registered from the next mode so it lines up with mode_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode_q     <= MODE_DRAIN;
            drain_q    <= 2'd2;
            cpu_hold_q <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            drain_q    <= drain_d;
            cpu_hold_q <= (mode_d != MODE_RUN);
        end
    end

    assign cpu_hold = cpu_hold_q;
    assign ld_wgnt  = (mode_q == MODE_LOAD) && ld_wreq;
    assign cpu_wgnt = (mode_q == MODE_RUN) && cpu_wreq;
    assign ram_cea  = ld_wgnt || cpu_wgnt;
    assign ram_ada  = ld_wgnt ? ld_waddr : cpu_waddr;
    assign ram_din  = ld_wgnt ? ld_wdata : cpu_wdata;
    assign ram_oce  = 1'b1;

    sdpb_rd_sched #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_VIDEO_BURST (MAX_VIDEO_BURST)
    ) u_rd_sched (
        .clk        (clk),
        .resetn     (resetn),
        .run        (mode_q == MODE_RUN),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .cpu_rreq   (cpu_rreq),
        .cpu_raddr  (cpu_raddr),
        .wr_en      (ram_cea),
        .wr_addr    (ram_ada),
        .wr_data    (ram_din),
        .ram_dout   (ram_dout),
        .vid_gnt    (vid_gnt),
        .cpu_rgnt   (cpu_rgnt),
        .vid_rvalid (vid_rvalid),
        .cpu_rvalid (cpu_rvalid),
        .rd_data    (w_rd_data),
        .ram_ceb    (ram_ceb),
        .ram_adb    (ram_adb)
    );

    assign vid_rdata = w_rd_data;
    assign cpu_rdata = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_sdpb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdpb_arbiter : directed bench for sdpb_arbiter with a read-response queue
// Revision        : 1.0
// ============================================================================
module tb_sdpb_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          vid_req, cpu_rreq, cpu_wreq, ld_active, ld_wreq;
    logic [AW-1:0] vid_addr, cpu_raddr, cpu_waddr, ld_waddr;
    logic [DW-1:0] cpu_wdata, ld_wdata;
    logic          vid_gnt, vid_rvalid, cpu_rgnt, cpu_rvalid, cpu_wgnt, ld_wgnt, cpu_hold;
    logic [DW-1:0] vid_rdata, cpu_rdata, ram_din, ram_dout;
    logic          ram_cea, ram_ceb, ram_oce;
    logic [AW-1:0] ram_ada, ram_adb;

    typedef struct {
        logic          vid;
        logic          cpu;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         sb[$];
    logic [DW-1:0] mem[int];
    logic [DW-1:0] shadow[int];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    sdpb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VIDEO_BURST(8)) dut (
        .clk(clk), .resetn(resetn),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_rreq(cpu_rreq), .cpu_raddr(cpu_raddr), .cpu_rgnt(cpu_rgnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_wreq(cpu_wreq), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wgnt(cpu_wgnt),
        .ld_active(ld_active), .ld_wreq(ld_wreq), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .ld_wgnt(ld_wgnt), .cpu_hold(cpu_hold),
        .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
        .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce), .ram_dout(ram_dout)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {3'b000, a} ^ 16'hA55A;
    endfunction

    // RAM macro model: read-before-write, one-cycle registered read.
    always @(posedge clk) begin
        if (ram_ceb) ram_dout <= mem.exists(int'(ram_adb)) ? mem[int'(ram_adb)] : pat(ram_adb);
        if (ram_cea) mem[int'(ram_ada)] = ram_din;
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One cycle: inputs already driven; check responses to last cycle's grants,
    // check this cycle's grants, then queue the expected response.
    task automatic step(input string tag, input logic evg, input logic ecg, input logic ecw,
                        input logic elw, input logic ehold, input logic chk_g);
        resp_t         r, n;
        logic [AW-1:0] ra;
        @(negedge clk);
        r = sb.pop_front();
        chk({tag, "/vid_rvalid"}, {31'd0, vid_rvalid}, {31'd0, r.vid});
        chk({tag, "/cpu_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, r.cpu});
        if (r.vid) chk({tag, "/vid_rdata"}, {16'd0, vid_rdata}, {16'd0, r.data});
        if (r.cpu) chk({tag, "/cpu_rdata"}, {16'd0, cpu_rdata}, {16'd0, r.data});
        if (chk_g) begin
            chk({tag, "/vid_gnt"},  {31'd0, vid_gnt},  {31'd0, evg});
            chk({tag, "/cpu_rgnt"}, {31'd0, cpu_rgnt}, {31'd0, ecg});
            chk({tag, "/cpu_wgnt"}, {31'd0, cpu_wgnt}, {31'd0, ecw});
            chk({tag, "/ld_wgnt"},  {31'd0, ld_wgnt},  {31'd0, elw});
            chk({tag, "/ram_cea"},  {31'd0, ram_cea},  {31'd0, ecw | elw});
            chk({tag, "/ram_ceb"},  {31'd0, ram_ceb},  {31'd0, evg | ecg});
        end
        chk({tag, "/cpu_hold"}, {31'd0, cpu_hold}, {31'd0, ehold});
        ra     = evg ? vid_addr : cpu_raddr;
        n.vid  = resetn && evg;
        n.cpu  = resetn && ecg;
        n.data = exp_rd(ra);
        if (ecw && cpu_waddr == ra) n.data = cpu_wdata;
        if (elw && ld_waddr == ra)  n.data = ld_wdata;
        if (resetn && ecw) shadow[int'(cpu_waddr)] = cpu_wdata;
        if (resetn && elw) shadow[int'(ld_waddr)]  = ld_wdata;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; vid_req = 1'b0; cpu_rreq = 1'b0; cpu_wreq = 1'b0;
        ld_active = 1'b0; ld_wreq = 1'b0;
        vid_addr = '0; cpu_raddr = '0; cpu_waddr = '0; ld_waddr = '0;
        cpu_wdata = '0; ld_wdata = '0;
        sb.push_back('{vid: 1'b0, cpu: 1'b0, data: 16'h0});
        @(posedge clk);
        #1;
        chk("ram_oce", {31'd0, ram_oce}, 32'd1);
        step("rst0", 0, 0, 0, 0, 1, 1);
        step("rst1", 0, 0, 0, 0, 1, 1);

        // Reset release: two held cycles with a pending CPU read, then RUN.
        resetn = 1'b1; cpu_rreq = 1'b1; cpu_raddr = 13'h0040;
        step("drain0", 0, 0, 0, 0, 1, 1);
        step("drain1", 0, 0, 0, 0, 1, 1);
        step("run0",   0, 1, 0, 0, 0, 1);

        // Contested reads: 8 video grants then one CPU grant, twice.
        vid_req = 1'b1; cpu_raddr = 13'h0200;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k < 8; k++) begin
                vid_addr = 13'(16 + 8 * rnd + k);
                step("burst_vid", 1, 0, 0, 0, 0, 1);
            end
            step("burst_cpu", 0, 1, 0, 0, 0, 1);
        end
        vid_req = 1'b0; cpu_rreq = 1'b0;
        step("burst_end", 0, 0, 0, 0, 0, 1);

        // Same-cycle write and read of 0x0100 forwards the new data.
        cpu_wreq = 1'b1; cpu_waddr = 13'h0100; cpu_wdata = 16'h1234;
        cpu_rreq = 1'b1; cpu_raddr = 13'h0100;
        step("fwd", 0, 1, 1, 0, 0, 1);
        cpu_wreq = 1'b0;
        step("rd100", 0, 1, 0, 0, 0, 1);
        cpu_rreq = 1'b0;

        // Loader session; ld_active takes effect from the next cycle.
        ld_active = 1'b1;
        step("ld_rise", 0, 0, 0, 0, 0, 1);
        cpu_rreq = 1'b1; cpu_raddr = 13'h0020;
        cpu_wreq = 1'b1; cpu_waddr = 13'h0021; cpu_wdata = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            ld_wreq = 1'b1; ld_waddr = 13'(i); ld_wdata = 16'hC000 | 16'(i);
            step("ld_wr", 0, 0, 0, 1, 1, 1);
        end
        ld_active = 1'b0; ld_wreq = 1'b0; cpu_rreq = 1'b0; cpu_wreq = 1'b0;
        step("ld_fall", 0, 0, 0, 0, 1, 1);
        ld_active = 1'b1; cpu_wreq = 1'b1; cpu_waddr = 13'h0300; cpu_wdata = 16'hBEEF;
        step("drain_reld", 0, 0, 0, 0, 1, 1);
        ld_wreq = 1'b1; ld_waddr = 13'h0003; ld_wdata = 16'h5A5A;
        step("reload", 0, 0, 0, 1, 1, 1);
        ld_active = 1'b0; ld_wreq = 1'b0;
        step("ld_fall2", 0, 0, 0, 0, 1, 1);
        step("drain_w0", 0, 0, 0, 0, 1, 1);
        step("drain_w1", 0, 0, 0, 0, 1, 1);
        step("run_w",    0, 0, 1, 0, 0, 1);
        cpu_wreq = 1'b0;

        // Read back write and loader results, and the top address.
        cpu_rreq = 1'b1;
        cpu_raddr = 13'h0300; step("rd300", 0, 1, 0, 0, 0, 1);
        cpu_raddr = 13'h0003; step("rd3",   0, 1, 0, 0, 0, 1);
        cpu_raddr = 13'h0001; step("rd1",   0, 1, 0, 0, 0, 1);
        cpu_raddr = 13'h0021; step("rd21",  0, 1, 0, 0, 0, 1);
        cpu_rreq = 1'b0;
        step("idle", 0, 0, 0, 0, 0, 1);
        cpu_rreq = 1'b1; cpu_raddr = 13'h1FFF;
        step("rd_top", 0, 1, 0, 0, 0, 1);
        cpu_rreq = 1'b0;
        step("rd_top_rsp", 0, 0, 0, 0, 0, 1);

        // Reset during a CPU read grant: no response afterwards.
        cpu_rreq = 1'b1; cpu_raddr = 13'h0005; resetn = 1'b0;
        step("rst_mid", 0, 1, 0, 0, 0, 0);
        resetn = 1'b1; cpu_rreq = 1'b0;
        step("post_rst0", 0, 0, 0, 0, 1, 1);
        step("post_rst1", 0, 0, 0, 0, 1, 1);
        step("post_run",  0, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdpb_arbiter.md
# sdpb_arbiter

Shares the 8K x 16 simple dual-port block RAM (one write port A, one read port B, 1-cycle registered read) between the video fetch unit, the CPU, and the boot loader. It sits between these requesters and the RAM macro, and drives the macro's CE, address and data pins directly. It arbitrates each port every cycle, bounds CPU read starvation, forwards same-cycle write data to reads, and holds the CPU during and just after a program load.

## Interface
- ADDR_W, 13, word address width (8192 words).
- DATA_W, 16, data width.
- MAX_VIDEO_BURST, 8, consecutive video read grants allowed while a CPU read waits; range 1..255.

- clk  in  1  single clock for both RAM ports.
- resetn  in  1  synchronous, active-low reset.
- vid_req  in  1  video read request; held until granted.
- vid_addr  in  ADDR_W  video read address.
- vid_gnt  out  1  video read issued this cycle.
- vid_rvalid  out  1  video read data valid (one cycle after vid_gnt).
- vid_rdata  out  DATA_W  video read data.
- cpu_rreq  in  1  CPU read request; held until granted.
- cpu_raddr  in  ADDR_W  CPU read address.
- cpu_rgnt  out  1  CPU read issued this cycle.
- cpu_rvalid  out  1  CPU read data valid (one cycle after cpu_rgnt).
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_wreq  in  1  CPU write request.
- cpu_waddr  in  ADDR_W  CPU write address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_wgnt  out  1  CPU write performed this cycle.
- ld_active  in  1  loader owns the write port and stalls the CPU while high.
- ld_wreq  in  1  loader write request.
- ld_waddr  in  ADDR_W  loader write address.
- ld_wdata  in  DATA_W  loader write data.
- ld_wgnt  out  1  loader write performed this cycle.
- cpu_hold  out  1  CPU stall.
- ram_cea  out  1  RAM write enable.
- ram_ada  out  ADDR_W  RAM write address.
- ram_din  out  DATA_W  RAM write data.
- ram_ceb  out  1  RAM read enable.
- ram_adb  out  ADDR_W  RAM read address.
- ram_oce  out  1  RAM output enable; constant 1.
- ram_dout  in  DATA_W  RAM read data, valid in the cycle after ram_ceb.

## Operation
- Mode FSM has three states: RUN, LOAD, DRAIN.
  - Reset enters DRAIN with the drain count set to 2.
  - RUN goes to LOAD when ld_active=1.
  - LOAD goes to DRAIN (count 2) when ld_active=0.
  - DRAIN decrements the count each cycle. It goes to LOAD if ld_active=1; otherwise it goes to RUN when the count reaches 0.
  - cpu_hold=1 in LOAD and DRAIN.
- Write port:
  - LOAD: only the loader can be granted (ld_wgnt=ld_wreq).
  - RUN: only the CPU can be granted (cpu_wgnt=cpu_wreq).
  - DRAIN: no write is granted.
  - ram_cea equals the OR of both grants; ram_ada and ram_din are muxed from the granted requester.
- Read port:
  - CPU reads are granted only in RUN.
  - Video has priority over the CPU.
  - Starvation counter: increments on each cycle where vid_gnt=1 while cpu_rreq is pending in RUN, and clears on cpu_rgnt or when cpu_rreq=0. When it equals MAX_VIDEO_BURST, the next contested cycle grants the CPU, drops vid_gnt, and clears the counter.
  - ram_ceb equals the OR of the read grants; ram_adb is muxed from the granted requester.
- Response routing:
  - A registered owner tag (NONE/VID/CPU) records which requester was granted the read.
  - The next cycle it drives the matching rvalid; the rdata bus is shared.
- Write forwarding:
  - When ram_cea and ram_ceb are both 1 and ram_ada==ram_adb, wdata and a hit flag are registered.
  - On a hit, the next cycle's rdata is the forwarded data instead of ram_dout.
- Reset values:
  - All gnt and rvalid outputs are 0, ram_cea=ram_ceb=0, and ram_oce=1.
  - cpu_hold=1; the starvation counter, owner tag (NONE) and hit flag are cleared.
  - rdata is don't-care while rvalid=0.

## Timing
- Grants and RAM CE/address are combinational from the requests and the registered state, in the same cycle.
- Read data arrives one cycle after the grant.
- Pipelined reads are supported: a new read can be granted every cycle.
- Reset mid-read: rvalid for the in-flight read is suppressed.
- ld_active rising during RUN takes effect on the write port from the next cycle, since the FSM is registered.
- A CPU write requested in the same cycle completes under RUN rules.

## Structure
- Package sdpb_arb_pkg holds:
  - ADDR_W and DATA_W defaults;
  - enum rd_owner_t {OWN_NONE, OWN_VID, OWN_CPU};
  - enum arb_mode_t {MODE_RUN, MODE_LOAD, MODE_DRAIN}.
- Sub-module sdpb_rd_sched contains the read-port priority logic, the starvation counter, the owner tag and write forwarding. The top level holds the mode FSM and the write mux.

## Test plan
- Reset release with ld_active=0: cpu_hold=1 for exactly 2 cycles, then 0. No grants occur during that window.
- vid_req and cpu_rreq held high with MAX_VIDEO_BURST=8: vid_gnt is high for 8 cycles, then cpu_rgnt is high for 1 cycle, and the pattern repeats. The rvalids appear 1 cycle after their grants, with the matching ram_dout data.
- Write 0x1234 to address 0x0100 and read 0x0100 in the same cycle: the next cycle's rdata is 0x1234, even though the model RAM returns old data.
- ld_active high with loader writes to 0x0000..0x0003: ld_wgnt=1, cpu_rgnt=0, cpu_wgnt=0, cpu_hold=1. After ld_active falls, cpu_hold stays 1 for 2 cycles; ld_active re-asserting mid-DRAIN returns to LOAD.
- CPU read alone in RUN at 0x1FFF (the top address): cpu_rgnt the same cycle and cpu_rvalid the next cycle with RAM content. resetn asserted in the grant cycle results in no cpu_rvalid.
- cpu_wreq during DRAIN: cpu_wgnt=0 and ram_cea=0 until RUN, then the write is granted.
